// File: rtl/tick_monitor_pkg.sv
// Shared register map, CH word bit positions and the channel status record
// used by the tick monitor and its channel sub-module.
package tick_monitor_pkg;

  localparam logic [7:0] ADDR_BOOT     = 8'h00;
  localparam logic [7:0] ADDR_SOF_SEQ  = 8'h01;
  localparam logic [7:0] ADDR_TIME     = 8'h02;
  localparam logic [7:0] ADDR_SOF_TIME = 8'h03;
  localparam logic [7:0] ADDR_CH_BASE  = 8'h08;

  localparam int MAX_CH        = 8;
  localparam int CH_BIT_SAT    = 0;
  localparam int CH_BIT_STICKY = 1;
  localparam int CH_CAP_LSB    = 16;

  typedef struct packed {
    logic [15:0] cap;
    logic        sticky;
    logic        sat;
  } ch_status_t;

  // Pack a channel status into its bus word; unused bits read as zero.
  function automatic logic [31:0] ch_word(input ch_status_t st);
    logic [31:0] w;
    w = '0;
    w[CH_CAP_LSB +: 16] = st.cap;
    w[CH_BIT_STICKY]    = st.sticky;
    w[CH_BIT_SAT]       = st.sat;
    return w;
  endfunction

endpackage

// File: rtl/tick_monitor_chan.sv
// One tick channel: saturating interval counter, capture on SOF,
// last-interval saturation flag and a W1C sticky overflow flag.
module tick_chan #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             sof_i,
  input  logic             clr_sticky_i,
  output logic [CNT_W-1:0] cap_o,
  output logic             cap_sat_o,
  output logic             sticky_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cap_q, cap_d;
  logic             sat_pend_q, sat_pend_d;
  logic             cap_sat_q, cap_sat_d;
  logic             sticky_q, sticky_d;

  always_comb begin
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    sat_pend_d = sat_pend_q;
    cap_sat_d  = cap_sat_q;
    if (sof_i) begin
      cap_d      = cnt_q;
      cap_sat_d  = sat_pend_q;
      // A tick coinciding with SOF is the first event of the new interval.
      cnt_d      = CNT_W'(tick_i);
      sat_pend_d = 1'b0;
    end else if (tick_i) begin
      if (cnt_q == CNT_MAX) begin
        sat_pend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // A freshly saturated interval overrides a clear on the same edge.
    sticky_d = (sticky_q & ~clr_sticky_i) | (sof_i & sat_pend_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      cap_q      <= '0;
      sat_pend_q <= 1'b0;
      cap_sat_q  <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      sat_pend_q <= sat_pend_d;
      cap_sat_q  <= cap_sat_d;
      sticky_q   <= sticky_d;
    end
  end

  assign cap_o     = cap_q;
  assign cap_sat_o = cap_sat_q;
  assign sticky_o  = sticky_q;

endmodule

// File: rtl/tick_monitor.sv
// Per-channel tick delta monitor over USB SOF intervals, with SOF timestamp,
// SOF sequence number and boot request register behind a Wishbone slave.
module tick_monitor
  import tick_monitor_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 16,
  parameter int TIME_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] tick,
  input  logic            tick_sof,
  output logic [1:0]      boot_sel,
  output logic            boot_now,
  input  logic [7:0]      wb_addr,
  output logic [31:0]     wb_rdata,
  input  logic [31:0]     wb_wdata,
  input  logic            wb_we,
  input  logic            wb_cyc,
  output logic            wb_ack
);

  logic              ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TIME_W-1:0] sof_time_q, sof_time_d;
  logic [15:0]       sof_seq_q, sof_seq_d;
  logic [2:0]        boot_q, boot_d;

  logic        wr_stb;
  logic        rd_start;
  logic [31:0] rd_mux;
  logic [MAX_CH-1:0] clr_sticky;
  ch_status_t  ch_stat [MAX_CH];

  logic unused_wdata;
  assign unused_wdata = ^{wb_wdata[31:3]};

  assign wr_stb   = wb_cyc & wb_we & ack_q;
  assign rd_start = wb_cyc & ~ack_q;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_CH; gi++) begin : g_ch
      if (gi < N_CH) begin : g_used
        logic [CNT_W-1:0] cap;
        logic             cap_sat;
        logic             sticky;

        assign clr_sticky[gi] = wr_stb & (wb_addr == 8'(ADDR_CH_BASE + gi))
                                & wb_wdata[CH_BIT_STICKY];

        tick_chan #(
          .CNT_W(CNT_W)
        ) u_chan (
          .clk         (clk),
          .rst         (rst),
          .tick_i      (tick[gi]),
          .sof_i       (tick_sof),
          .clr_sticky_i(clr_sticky[gi]),
          .cap_o       (cap),
          .cap_sat_o   (cap_sat),
          .sticky_o    (sticky)
        );

        assign ch_stat[gi] = '{cap: 16'(cap), sticky: sticky, sat: cap_sat};
      end else begin : g_absent
        assign clr_sticky[gi] = 1'b0;
        assign ch_stat[gi]    = '0;
      end
    end
  endgenerate

  // Registers are sampled before the edge, so a read racing a SOF sees the old capture.
  always_comb begin
    rd_mux = '0;
    if (wb_addr[7:3] == ADDR_CH_BASE[7:3]) begin
      rd_mux = ch_word(ch_stat[wb_addr[2:0]]);
    end else begin
      case (wb_addr)
        ADDR_BOOT:     rd_mux = {29'd0, boot_q};
        ADDR_SOF_SEQ:  rd_mux = {16'd0, sof_seq_q};
        ADDR_TIME:     rd_mux = 32'(time_q);
        ADDR_SOF_TIME: rd_mux = 32'(sof_time_q);
        default:       rd_mux = '0;
      endcase
    end
  end

  always_comb begin
    ack_d      = rd_start;
    rdata_d    = rd_start ? rd_mux : 32'd0;
    time_d     = time_q + TIME_W'(1);
    sof_time_d = sof_time_q;
    sof_seq_d  = sof_seq_q;
    boot_d     = boot_q;
    if (tick_sof) begin
      sof_time_d = time_q;
      sof_seq_d  = sof_seq_q + 16'd1;
    end
    if (wr_stb && (wb_addr == ADDR_BOOT)) begin
      boot_d = wb_wdata[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      time_q     <= '0;
      sof_time_q <= '0;
      sof_seq_q  <= '0;
      boot_q     <= '0;
    end else begin
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      time_q     <= time_d;
      sof_time_q <= sof_time_d;
      sof_seq_q  <= sof_seq_d;
      boot_q     <= boot_d;
    end
  end

  assign wb_ack   = ack_q;
  assign wb_rdata = rdata_q;
  assign boot_sel = boot_q[1:0];
  assign boot_now = boot_q[2];

endmodule

// File: tb/tb_tick_monitor.sv
// Directed bench: a default-parameter monitor and a CNT_W=4 monitor share
// the bus and SOF; each has its own tick lines.
module tb_tick_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  tick_a, tick_b;
  logic        tick_sof;
  logic [7:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we, wb_cyc;
  logic [1:0]  boot_sel_a, boot_sel_b;
  logic        boot_now_a, boot_now_b;
  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, ack_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tick_monitor #(.N_CH(2), .CNT_W(16), .TIME_W(32)) dut_a (
    .clk(clk), .rst(rst), .tick(tick_a), .tick_sof(tick_sof),
    .boot_sel(boot_sel_a), .boot_now(boot_now_a),
    .wb_addr(wb_addr), .wb_rdata(rdata_a), .wb_wdata(wb_wdata),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(ack_a)
  );

  tick_monitor #(.N_CH(2), .CNT_W(4), .TIME_W(32)) dut_b (
    .clk(clk), .rst(rst), .tick(tick_b), .tick_sof(tick_sof),
    .boot_sel(boot_sel_b), .boot_now(boot_now_b),
    .wb_addr(wb_addr), .wb_rdata(rdata_b), .wb_wdata(wb_wdata),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(ack_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus access: cyc held through the ack cycle, dropped on the following negedge.
  task automatic bus(input string tag, input logic [7:0] a, input logic we,
                     input logic [31:0] wd, output logic [31:0] ra, output logic [31:0] rb);
    @(negedge clk);
    wb_addr = a; wb_we = we; wb_wdata = wd; wb_cyc = 1'b1;
    @(posedge clk); #1;
    check({tag, " ack_hi"}, {30'd0, ack_a, ack_b}, 32'd3);
    ra = rdata_a; rb = rdata_b;
    @(posedge clk); #1;
    check({tag, " ack_lo"}, {30'd0, ack_a, ack_b}, 32'd0);
    check({tag, " rdata_idle"}, rdata_a | rdata_b, 32'd0);
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0;
    $display("bus %s addr=0x%02h we=%0d wdata=0x%08h rdata_a=0x%08h rdata_b=0x%08h",
             tag, a, we, wd, ra, rb);
  endtask

  task automatic ticks(input int n, input logic [1:0] ma, input logic [1:0] mb);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick_a = ma; tick_b = mb;
      @(negedge clk); tick_a = 2'b00; tick_b = 2'b00;
    end
  endtask

  task automatic sof(input logic [1:0] ma);
    @(negedge clk); tick_sof = 1'b1; tick_a = ma;
    @(negedge clk); tick_sof = 1'b0; tick_a = 2'b00;
  endtask

  logic [31:0] ra, rb, t1, t2;

  initial begin
    rst = 1'b1; tick_a = '0; tick_b = '0; tick_sof = 1'b0;
    wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_cyc = 1'b0;

    // 1 Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst boot_sel", {30'd0, boot_sel_a}, 32'd0);
    check("rst boot_now", {31'd0, boot_now_a}, 32'd0);
    check("rst ack", {30'd0, ack_a, ack_b}, 32'd0);
    check("rst rdata", rdata_a, 32'd0);
    bus("rd BOOT", 8'h00, 1'b0, 32'd0, ra, rb);
    check("rst BOOT", ra, 32'd0);
    bus("rd SEQ", 8'h01, 1'b0, 32'd0, ra, rb);
    check("rst SOF_SEQ", ra, 32'd0);
    bus("rd CH0", 8'h08, 1'b0, 32'd0, ra, rb);
    check("rst CH0", ra, 32'd0);

    // 2 Delta: 37 on ch0, 5 on ch1
    sof(2'b00);
    ticks(5, 2'b11, 2'b00);
    ticks(32, 2'b01, 2'b00);
    sof(2'b00);
    bus("rd CH0", 8'h08, 1'b0, 32'd0, ra, rb);
    check("delta CH0", ra, 32'h0025_0000);
    check("delta CH0 b", rb, 32'h0000_0000);
    bus("rd CH1", 8'h09, 1'b0, 32'd0, ra, rb);
    check("delta CH1", ra, 32'h0005_0000);
    bus("rd SEQ", 8'h01, 1'b0, 32'd0, ra, rb);
    check("delta SOF_SEQ", ra, 32'd2);

    // 3 Saturation on the CNT_W=4 instance
    ticks(20, 2'b00, 2'b01);
    sof(2'b00);
    bus("rd CH0", 8'h08, 1'b0, 32'd0, ra, rb);
    check("sat CH0", rb, 32'h000F_0003);
    bus("w1c CH0", 8'h08, 1'b1, 32'h2, ra, rb);
    bus("rd CH0", 8'h08, 1'b0, 32'd0, ra, rb);
    check("sat after w1c", rb, 32'h000F_0001);
    sof(2'b00);
    bus("rd CH0", 8'h08, 1'b0, 32'd0, ra, rb);
    check("sat cleared", rb, 32'h0000_0000);

    // SOF on the same edge as the W1C strobe: new saturation keeps sticky set
    ticks(20, 2'b00, 2'b01);
    @(negedge clk);
    wb_addr = 8'h08; wb_we = 1'b1; wb_wdata = 32'h2; wb_cyc = 1'b1;
    @(negedge clk); tick_sof = 1'b1;
    @(negedge clk); tick_sof = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    $display("bus w1c+sof addr=0x08 we=1 wdata=0x00000002");
    bus("rd CH0", 8'h08, 1'b0, 32'd0, ra, rb);
    check("w1c vs sof", rb, 32'h000F_0003);

    // 4 Tick coinciding with SOF
    ticks(3, 2'b01, 2'b00);
    sof(2'b01);
    bus("rd CH0", 8'h08, 1'b0, 32'd0, ra, rb);
    check("same-cycle cap", ra, 32'h0003_0000);
    sof(2'b00);
    bus("rd CH0", 8'h08, 1'b0, 32'd0, ra, rb);
    check("carried tick", ra, 32'h0001_0000);
    bus("rd SEQ", 8'h01, 1'b0, 32'd0, ra, rb);
    check("SOF_SEQ total", ra, 32'd7);

    // 5 Boot
    bus("wr BOOT", 8'h00, 1'b1, 32'h6, ra, rb);
    check("boot_now", {31'd0, boot_now_a}, 32'd1);
    check("boot_sel", {30'd0, boot_sel_a}, 32'd2);
    bus("rd BOOT", 8'h00, 1'b0, 32'd0, ra, rb);
    check("BOOT readback", ra, 32'h6);

    // 6 Bus: unmapped, absent channel, TIME spacing
    bus("rd 0x1F", 8'h1F, 1'b0, 32'd0, ra, rb);
    check("unmapped", ra, 32'd0);
    bus("rd CH2", 8'h0A, 1'b0, 32'd0, ra, rb);
    check("absent ch", ra, 32'd0);
    bus("rd TIME", 8'h02, 1'b0, 32'd0, t1, rb);
    repeat (10) @(negedge clk);
    bus("rd TIME", 8'h02, 1'b0, 32'd0, t2, rb);
    // 10 idle cycles plus the 3-cycle bus access spacing
    check("TIME delta", t2 - t1, 32'd13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
